io_bus_arbiter: RTL and testbench

- Two-master arbiter and transaction sequencer for the 16-bit peripheral I/O bus between the J1 core and the address decoder/read mux of the SoC top.
- Master 0 is the J1 I/O port; master 1 is an auxiliary master, e.g. a DMA moving audio samples into dpRAM.
- Grants the bus one transaction at a time, drives single-cycle rd/wr strobes, inserts read wait states and returns read data with a one-cycle ack.

---
 rtl/io_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter and transaction sequencer for the 16-bit peripheral I/O bus.
// Serves one transaction at a time: single-cycle strobe, optional read wait states, one-cycle ack.
module io_bus_arbiter #(
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        io_rd,
  output logic        io_wr,
  output logic [15:0] io_addr,
  output logic [15:0] io_dout,
  input  logic [15:0] io_din,
  output logic [1:0]  grant
);

  // state  | meaning
  // IDLE   | no owner; requests arbitrated at the next edge
  // STROBE | one-cycle io_rd/io_wr pulse for the owner
  // WAIT   | read wait states; address held, cnt counting down
  // ACK    | one-cycle ack to the owner, bus released at exit
  typedef enum logic [1:0] {IDLE, STROBE, WAIT, ACK} state_t;

  localparam logic [3:0] WAIT_LOAD = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  grant_r, grant_nxt;
  logic        last_grant, last_grant_nxt;
  logic        wr_r, wr_nxt;
  logic [15:0] addr_r, addr_nxt;
  logic [15:0] wdata_r, wdata_nxt;
  logic [15:0] rdata0_r, rdata0_nxt;
  logic [15:0] rdata1_r, rdata1_nxt;
  logic        pick_m1;
  logic        capture;

  // last_grant holds the index of the previous owner; m1 wins a tie only if m0 went last.
  assign pick_m1 = m1_req && (!m0_req || ((FIXED_PRIO == 0) && !last_grant));

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      grant_r    <= '0;
      last_grant <= 1'b1;
      wr_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata0_r   <= '0;
      rdata1_r   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      grant_r    <= grant_nxt;
      last_grant <= last_grant_nxt;
      wr_r       <= wr_nxt;
      addr_r     <= addr_nxt;
      wdata_r    <= wdata_nxt;
      rdata0_r   <= rdata0_nxt;
      rdata1_r   <= rdata1_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    grant_nxt      = grant_r;
    last_grant_nxt = last_grant;
    wr_nxt         = wr_r;
    addr_nxt       = addr_r;
    wdata_nxt      = wdata_r;
    rdata0_nxt     = rdata0_r;
    rdata1_nxt     = rdata1_r;
    capture        = 1'b0;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_nxt      = pick_m1 ? 2'b10 : 2'b01;
          last_grant_nxt = pick_m1;
          wr_nxt         = pick_m1 ? m1_wr    : m0_wr;
          addr_nxt       = pick_m1 ? m1_addr  : m0_addr;
          wdata_nxt      = pick_m1 ? m1_wdata : m0_wdata;
          state_nxt      = STROBE;
        end
      end
      STROBE: begin
        if (wr_r) begin
          state_nxt = ACK;
        end else if (RD_WAIT == 0) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end else begin
          cnt_nxt   = WAIT_LOAD;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK: begin
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (capture) begin
      if (grant_r[0]) rdata0_nxt = io_din;
      if (grant_r[1]) rdata1_nxt = io_din;
    end
  end

  // io_addr stays on addr_r through WAIT and ACK so chip-select and read-mux selection remain stable.
  assign io_rd    = (state == STROBE) && !wr_r;
  assign io_wr    = (state == STROBE) && wr_r;
  assign io_addr  = addr_r;
  assign io_dout  = ((state == STROBE) && wr_r) ? wdata_r : 16'h0000;
  assign grant    = grant_r;
  assign m0_ack   = (state == ACK) && grant_r[0];
  assign m1_ack   = (state == ACK) && grant_r[1];
  assign m0_rdata = rdata0_r;
  assign m1_rdata = rdata1_r;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: two instances (round-robin with RD_WAIT=2, fixed priority with RD_WAIT=0).
// Expected acks are queued per instance; a negedge monitor pops and checks master, cycle, address, data.
module tb_io_bus_arbiter;

  typedef struct {
    int          m;
    bit          is_rd;
    logic [15:0] data;
    logic [15:0] addr;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_b [2];
  logic        req   [2][2];
  logic        wr    [2][2];
  logic [15:0] addr  [2][2];
  logic [15:0] wdata [2][2];
  logic        ack   [2][2];
  logic [15:0] rdata [2][2];
  logic        io_rd [2];
  logic        io_wr [2];
  logic [15:0] io_addr [2];
  logic [15:0] io_dout [2];
  logic [15:0] din [2];
  logic [1:0]  grant [2];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  io_bus_arbiter #(.RD_WAIT(2), .FIXED_PRIO(0)) u_a (
    .sys_clk_i(clk), .sys_rst_i(rst_b[0]),
    .m0_req(req[0][0]), .m0_wr(wr[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_ack(ack[0][0]), .m0_rdata(rdata[0][0]),
    .m1_req(req[0][1]), .m1_wr(wr[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_ack(ack[0][1]), .m1_rdata(rdata[0][1]),
    .io_rd(io_rd[0]), .io_wr(io_wr[0]), .io_addr(io_addr[0]), .io_dout(io_dout[0]),
    .io_din(din[0]), .grant(grant[0])
  );

  io_bus_arbiter #(.RD_WAIT(0), .FIXED_PRIO(1)) u_b (
    .sys_clk_i(clk), .sys_rst_i(rst_b[1]),
    .m0_req(req[1][0]), .m0_wr(wr[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_ack(ack[1][0]), .m0_rdata(rdata[1][0]),
    .m1_req(req[1][1]), .m1_wr(wr[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_ack(ack[1][1]), .m1_rdata(rdata[1][1]),
    .io_rd(io_rd[1]), .io_wr(io_wr[1]), .io_addr(io_addr[1]), .io_dout(io_dout[1]),
    .io_din(din[1]), .grant(grant[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input int m, input bit is_rd, input logic [15:0] data,
                          input logic [15:0] a, input int c);
    exp_t e;
    e.m = m; e.is_rd = is_rd; e.data = data; e.addr = a; e.cyc = c;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic score(input int d, input int m);
    exp_t e;
    if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: dut%0d m%0d acked at cycle %0d, none expected", d, m, cyc);
      return;
    end
    e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
    chk("ack_master", 32'(m), 32'(e.m));
    chk("ack_cycle", cyc, e.cyc);
    chk("ack_io_addr", 32'(io_addr[d]), 32'(e.addr));
    if (e.is_rd) chk("ack_rdata", 32'(rdata[d][m]), 32'(e.data));
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_b[d] === 1'b1) begin
        chk("grant_not_both", 32'(grant[d] == 2'b11), 32'd0);
        chk("ack_not_both", 32'(ack[d][0] && ack[d][1]), 32'd0);
      end
      for (int m = 0; m < 2; m++)
        if (ack[d][m] === 1'b1) score(d, m);
    end
  end

  task automatic wait_ack(input int d, input int m);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack[d][m] !== 1'b1 && n < 60);
    if (ack[d][m] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: dut%0d m%0d got no ack within 60 cycles, required one", d, m);
    end
    @(posedge clk);
    #1;
  endtask

  // Keeps req high across transactions, presenting the next one at the edge that ends each ack.
  task automatic master_run(input int d, input int m, input int n, input logic w, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      req[d][m]   = 1'b1;
      wr[d][m]    = w;
      addr[d][m]  = base + 16'(i);
      wdata[d][m] = base ^ 16'h5A5A;
      wait_ack(d, m);
    end
    req[d][m] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    for (int d = 0; d < 2; d++) begin
      rst_b[d] = 1'b0;
      din[d]   = 16'h0666;
      for (int m = 0; m < 2; m++) begin
        req[d][m] = 1'b0; wr[d][m] = 1'b0; addr[d][m] = '0; wdata[d][m] = '0;
      end
    end

    // Reset held 3 cycles with an m0 write pending on instance A.
    req[0][0] = 1'b1; wr[0][0] = 1'b1; addr[0][0] = 16'h6900; wdata[0][0] = 16'h0041;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_no_wr", 32'(io_wr[0]), 32'd0);
      chk("reset_no_rd", 32'(io_rd[0]), 32'd0);
    end
    for (int d = 0; d < 2; d++) begin
      chk("reset_grant", 32'(grant[d]), 32'd0);
      chk("reset_io_addr", 32'(io_addr[d]), 32'd0);
      chk("reset_io_dout", 32'(io_dout[d]), 32'd0);
      chk("reset_m0_rdata", 32'(rdata[d][0]), 32'd0);
      chk("reset_m1_rdata", 32'(rdata[d][1]), 32'd0);
      chk("reset_m0_ack", 32'(ack[d][0]), 32'd0);
    end
    @(posedge clk); #1;
    rst_b[0] = 1'b1; rst_b[1] = 1'b1;
    e0 = cyc;
    push_exp(0, 0, 1'b0, 16'h0000, 16'h6900, e0 + 2);
    @(posedge clk);
    @(negedge clk);
    chk("first_grant", 32'(grant[0]), 32'h1);
    chk("first_io_wr", 32'(io_wr[0]), 32'd1);
    chk("first_io_rd", 32'(io_rd[0]), 32'd0);
    chk("first_io_addr", 32'(io_addr[0]), 32'h6900);
    chk("first_io_dout", 32'(io_dout[0]), 32'h0041);
    wait_ack(0, 0);
    req[0][0] = 1'b0;

    // m1 read with two wait states; read data only valid from the second cycle on.
    e0 = cyc;
    req[0][1] = 1'b1; wr[0][1] = 1'b0; addr[0][1] = 16'h6702; din[0] = 16'h1234;
    push_exp(0, 1, 1'b1, 16'hBEEF, 16'h6702, e0 + 4);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 2) din[0] = 16'hBEEF;
      @(negedge clk);
      chk("rd_strobe_pulse", 32'(io_rd[0]), 32'(k == 1));
      chk("rd_addr_held", 32'(io_addr[0]), 32'h6702);
      chk("rd_grant_m1", 32'(grant[0]), 32'h2);
    end
    @(posedge clk); #1;
    req[0][1] = 1'b0;
    chk("m0_rdata_untouched", 32'(rdata[0][0]), 32'd0);

    // Round-robin: both masters keep requesting, owners alternate every 3 cycles.
    e0 = cyc;
    for (int k = 0; k < 6; k++)
      push_exp(0, k % 2, 1'b0, 16'h0000, ((k % 2) ? 16'h2000 : 16'h1000) + 16'(k / 2), e0 + 2 + 3 * k);
    fork
      master_run(0, 0, 3, 1'b1, 16'h1000);
      master_run(0, 1, 3, 1'b1, 16'h2000);
    join

    // Fixed priority: m0 served until it drops req, then m1.
    e0 = cyc;
    for (int k = 0; k < 5; k++)
      push_exp(1, (k < 3) ? 0 : 1, 1'b0, 16'h0000,
               (k < 3) ? 16'h3000 + 16'(k) : 16'h4000 + 16'(k - 3), e0 + 2 + 3 * k);
    fork
      master_run(1, 0, 3, 1'b1, 16'h3000);
      master_run(1, 1, 2, 1'b1, 16'h4000);
    join

    // m0 read to give m0_rdata a nonzero value, then a read aborted by reset in WAIT.
    e0 = cyc;
    req[0][0] = 1'b1; wr[0][0] = 1'b0; addr[0][0] = 16'h6801; din[0] = 16'h1111;
    push_exp(0, 0, 1'b1, 16'h1111, 16'h6801, e0 + 4);
    wait_ack(0, 0);
    req[0][0] = 1'b0;
    @(posedge clk); #1;
    e0 = cyc;
    req[0][0] = 1'b1; wr[0][0] = 1'b0; addr[0][0] = 16'h6800; din[0] = 16'h7777;
    push_exp(0, 0, 1'b1, 16'h7777, 16'h6800, e0 + 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b[0] = 1'b0;
    @(posedge clk); #1;
    rst_b[0] = 1'b1;
    @(negedge clk);
    chk("abort_no_ack", 32'(ack[0][0]), 32'd0);
    chk("abort_m0_rdata", 32'(rdata[0][0]), 32'd0);
    chk("abort_m1_rdata", 32'(rdata[0][1]), 32'd0);
    chk("abort_grant", 32'(grant[0]), 32'd0);
    wait_ack(0, 0);
    req[0][0] = 1'b0;

    // Zero-wait reads on instance B; unmapped default passes through, m1 data kept.
    e0 = cyc;
    req[1][1] = 1'b1; wr[1][1] = 1'b0; addr[1][1] = 16'h6A00; din[1] = 16'hCAFE;
    push_exp(1, 1, 1'b1, 16'hCAFE, 16'h6A00, e0 + 2);
    wait_ack(1, 1);
    req[1][1] = 1'b0;
    @(posedge clk); #1;
    e0 = cyc;
    req[1][0] = 1'b1; wr[1][0] = 1'b0; addr[1][0] = 16'h5500; din[1] = 16'h0666;
    push_exp(1, 0, 1'b1, 16'h0666, 16'h5500, e0 + 2);
    wait_ack(1, 0);
    req[1][0] = 1'b0;
    chk("unmapped_m0_rdata", 32'(rdata[1][0]), 32'h0666);
    chk("m1_rdata_kept", 32'(rdata[1][1]), 32'hCAFE);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_a_drained", q_a.size(), 32'd0);
    chk("queue_b_drained", q_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
